muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multi-cycle executor for the RV32M operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) in the EX stage, alongside the main ALU. The ALU control path uses `funct7[0]` to identify an M-extension instruction. This block takes the undecoded `funct3` plus both operands, runs the operation over several cycles, and drives `busy` to the hazard unit so the pipeline stalls. It returns a 32-bit result with a one-cycle `done` pulse.

## Interface
- `XLEN`, default 32: operand and result width. The divide latency scales with it.
- `clk` input 1: the single clock.
- `rst` input 1: reset, synchronous, active-high.
- `start` input 1: request. It is sampled only when the unit is not `busy`.
- `funct3` input 3: operation select. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1` input XLEN: dividend / multiplicand.
- `rs2` input XLEN: divisor / multiplier.
- `kill` input 1: synchronous abort from a pipeline flush.
- `busy` output 1: operation in flight. The hazard unit stalls the pipeline while this is high.
- `done` output 1: one-cycle pulse; `result` is valid during it.
- `result` output XLEN: final value, held until the next accepted `start`.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- Accept:
  - `start` is accepted in IDLE or DONE (back-to-back allowed).
  - On accept, latch `funct3`, `rs1` and `rs2`.
  - For DIV/REM (100, 110): latch the absolute values of `rs1` and `rs2`, plus the quotient sign (`rs1[31]` XOR `rs2[31]`) and the remainder sign (`rs1[31]`).
- Multiply:
  - MUL state: form a 64-bit product from 33-bit extended operands.
    - `rs1` is sign-extended for MULH and MULHSU.
    - `rs2` is sign-extended for MULH only.
  - Register the product, then go to DONE.
  - MUL returns `product[31:0]`; the MULH variants return `product[63:32]`.
- Divide special cases (go directly to DONE with no iteration):
  - Divisor zero: quotient is all ones (0xFFFFFFFF); remainder is `rs1`. Applies to signed and unsigned.
  - Signed overflow (`rs1`=0x80000000, `rs2`=0xFFFFFFFF): quotient is 0x80000000; remainder is 0.
- Divide normal path:
  - DIV state runs XLEN restoring iterations with a 6-bit counter.
  - Each iteration shifts {rem, quo} left by one, trial-subtracts the divisor from rem, and keeps the difference when it is non-negative. Bit 0 of quo takes the inverted borrow.
  - After iteration XLEN-1, go to FIX.
  - FIX: negate the quotient and/or remainder per the latched signs (signed ops only), register the result, then go to DONE.
- DONE:
  - `done`=1 for exactly one cycle.
  - Next state is IDLE, or a new operation if `start` is high.
- `result` updates only on entry to DONE.
- `start` while `busy` is ignored: no latch, no error.
- `kill` in any state forces IDLE next cycle and suppresses `done`. `result` keeps its prior value. `kill` takes priority over `start` in the same cycle.
- `rst` has priority over `kill` and `start`.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, counter 0.
- `busy` = state ∈ {MUL, DIV, FIX}. It is registered, so it rises the cycle after accept.
- Latency, counted from the accept edge (cycle 0) to the `done`-high cycle:
  - Multiply: 2 cycles.
  - Divide special case: 2 cycles.
  - Normal divide: XLEN+2 = 34 cycles (DIV cycles 1–32, FIX cycle 33, DONE cycle 34).
- Throughput: a `start` in a DONE cycle is accepted, so its `done` arrives 2 or 34 cycles later. There is no idle bubble.
- Hazard contract: the issuing instruction holds `start`, `funct3` and the operands stable until `busy` rises. Only the accept-cycle values are used.
- `kill` during FIX or DONE entry:
  - A `kill` in the FIX cycle prevents `done`.
  - A `kill` during DONE does not retract the pulse already being driven.

## Structure
- `muldiv_pkg`: `funct3` localparams (F3_MUL … F3_REMU), state enum, and a DIV_ITERS constant equal to XLEN.
- One sub-module, `div_core`: the iterative restoring divider on magnitudes, with load/step inputs and quo/rem outputs.
- The top level owns the FSM, the operand sign handling, the multiplier and the result mux.

## Test plan
- MUL, `rs1`=7, `rs2`=-3 (0xFFFFFFFD): `done` on cycle 2, `result`=0xFFFFFFEB. MULHU with the same operands gives `result`=0x00000006.
- MULH 0x80000000 × 0x80000000 gives 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF gives 0xFFFFFFFF.
- DIV -7 / 2: `busy` high for cycles 1–33, `done` on cycle 34, `result`=0xFFFFFFFD. REM with the same operands gives 0xFFFFFFFF. DIVU 100 / 7 gives 14; REMU gives 2.
- Special cases:
  - DIV 5 / 0 gives 0xFFFFFFFF and REM 5 / 0 gives 5, each with `done` on cycle 2.
  - DIV 0x80000000 / -1 gives 0x80000000; REM gives 0.
- Start during a divide at cycle 10: ignored, and the original result appears at cycle 34. `kill` at cycle 20: `busy` drops at cycle 21, no `done`, and `result` keeps its old value.
- Back-to-back: a MUL `start` during the DONE cycle of a DIV gives its `done` 2 cycles later. `rst` mid-divide returns every output to its reset value the next cycle.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 encodings,
// FSM state type and the default datapath width.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam int MD_XLEN   = 32;
    localparam int DIV_ITERS = MD_XLEN;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    function automatic logic is_busy_state(input state_e s);
        return (s == ST_MUL) || (s == ST_DIV) || (s == ST_FIX);
    endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit per step.
module div_core #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quo,
    output logic [W-1:0] rem
);
    logic [W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [W:0]   rem_sh_s;
    logic [W+1:0] diff_s;
    logic         borrow_s;

    // Shift {rem, quo} left by one; the extra bit keeps the trial subtract exact.
    assign rem_sh_s = {rem_q, quo_q[W-1]};
    assign diff_s   = {1'b0, rem_sh_s} - {2'b00, dvs_q};
    assign borrow_s = diff_s[W+1];

    // Next-state for the divider registers: load, iterate, or hold.
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        if (load) begin
            rem_d = {W{1'b0}};
            quo_d = dividend;
            dvs_d = divisor;
        end else if (step) begin
            rem_d = borrow_s ? rem_sh_s[W-1:0] : diff_s[W-1:0];
            quo_d = {quo_q[W-2:0], ~borrow_s};
        end else begin
            rem_d = rem_q;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= {W{1'b0}};
            quo_q <= {W{1'b0}};
            dvs_q <= {W{1'b0}};
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

    assign quo = quo_q;
    assign rem = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multi-cycle multiply/divide executor: FSM, sign handling, multiplier
// and result selection around the iterative divider core.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam logic [5:0]      LAST_ITER = 6'(XLEN - 1);
    localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q, state_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic            q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic            busy_q, busy_d, done_q, done_d;
    logic [5:0]      cnt_q, cnt_d;

    logic            accept_s, signed_div_s, div_load_s, div_step_s;
    logic            div_zero_s, div_ovf_s;
    logic [XLEN-1:0] rs1_mag_s, rs2_mag_s, quo_s, rem_s;
    logic [XLEN-1:0] quo_fix_s, rem_fix_s, mul_res_s, spec_res_s;
    logic [2*XLEN-1:0] mul_a_s, mul_b_s, prod_s;

    assign accept_s     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign signed_div_s = funct3[2] && !funct3[0];
    assign rs1_mag_s    = (signed_div_s && rs1[XLEN-1]) ? -rs1 : rs1;
    assign rs2_mag_s    = (signed_div_s && rs2[XLEN-1]) ? -rs2 : rs2;

    // Extending to the full product width keeps the low 2*XLEN bits exact for every sign mix.
    assign mul_a_s   = {{XLEN{((funct3_q == F3_MULH) || (funct3_q == F3_MULHSU)) && a_q[XLEN-1]}}, a_q};
    assign mul_b_s   = {{XLEN{(funct3_q == F3_MULH) && b_q[XLEN-1]}}, b_q};
    assign prod_s    = mul_a_s * mul_b_s;
    assign mul_res_s = (funct3_q == F3_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];

    assign div_zero_s = (b_q == {XLEN{1'b0}});
    assign div_ovf_s  = !funct3_q[0] && (a_q == MIN_NEG) && (b_q == ALL_ONES);
    assign spec_res_s = div_zero_s ? (funct3_q[1] ? a_q : ALL_ONES)
                                   : (funct3_q[1] ? {XLEN{1'b0}} : MIN_NEG);
    assign quo_fix_s  = q_neg_q ? -quo_s : quo_s;
    assign rem_fix_s  = r_neg_q ? -rem_s : rem_s;

    div_core #(.W(XLEN)) u_div_core (
        .clk      (clk),
        .rst      (rst),
        .load     (div_load_s),
        .step     (div_step_s),
        .dividend (rs1_mag_s),
        .divisor  (rs2_mag_s),
        .quo      (quo_s),
        .rem      (rem_s)
    );

    // Next-state, operand capture and result selection; kill overrides everything.
    always_comb begin
        state_d    = state_q;
        funct3_d   = funct3_q;
        a_d        = a_q;
        b_d        = b_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        div_load_s = 1'b0;
        div_step_s = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    funct3_d   = funct3;
                    a_d        = rs1;
                    b_d        = rs2;
                    q_neg_d    = signed_div_s && (rs1[XLEN-1] ^ rs2[XLEN-1]);
                    r_neg_d    = signed_div_s && rs1[XLEN-1];
                    cnt_d      = 6'd0;
                    div_load_s = funct3[2];
                    state_d    = funct3[2] ? ST_DIV : ST_MUL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                result_d = mul_res_s;
                state_d  = ST_DONE;
            end
            ST_DIV: begin
                if (div_zero_s || div_ovf_s) begin
                    result_d = spec_res_s;
                    state_d  = ST_DONE;
                end else begin
                    div_step_s = 1'b1;
                    cnt_d      = cnt_q + 6'd1;
                    state_d    = (cnt_q == LAST_ITER) ? ST_FIX : ST_DIV;
                end
            end
            ST_FIX: begin
                result_d = funct3_q[1] ? rem_fix_s : quo_fix_s;
                state_d  = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (kill) begin
            state_d    = ST_IDLE;
            cnt_d      = 6'd0;
            result_d   = result_q;
            div_load_s = 1'b0;
            div_step_s = 1'b0;
        end else begin
            cnt_d = cnt_d;
        end
        busy_d = is_busy_state(state_d);
        done_d = (state_d == ST_DONE);
    end

    // Control and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            funct3_q <= 3'b000;
            a_q      <= {XLEN{1'b0}};
            b_q      <= {XLEN{1'b0}};
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            cnt_q    <= 6'd0;
            result_q <= {XLEN{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            a_q      <= a_d;
            b_q      <= b_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed results and latencies.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst, start, kill;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2;
    logic        busy, done;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .kill   (kill),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive a request during the current cycle; returns just after the accept edge.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        funct3 = f3;
        rs1    = a;
        rs2    = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        funct3 = 3'b000;
        rs1    = 32'h0;
        rs2    = 32'h0;
    endtask

    // Returns at the negedge of the done cycle (or after the cycle budget).
    task automatic wait_done(input string tag, input logic [31:0] exp_res, input int exp_lat);
        int lat = 0;
        int busy_cyc = 0;
        bit seen = 1'b0;
        while (!seen && lat < 60) begin
            @(negedge clk);
            lat++;
            if (done) seen = 1'b1;
            else if (busy) busy_cyc++;
        end
        check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_val({tag, "_res"}, result, exp_res);
        check_val({tag, "_busy"}, 32'(busy_cyc), 32'(exp_lat - 1));
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        @(negedge clk);
        issue(f3, a, b);
        wait_done(tag, exp_res, exp_lat);
        @(negedge clk);
        check_val({tag, "_pulse"}, {31'd0, done}, 32'd0);
    endtask

    // Divide killed at cycle kcyc: busy must drop next cycle, no done, result kept.
    task automatic run_kill(input string tag, input int kcyc, input logic [31:0] prev);
        int lat = 0;
        int n_done = 0;
        @(negedge clk);
        issue(3'b101, 32'd9, 32'd3);
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (done) n_done++;
            if (lat == kcyc) kill = 1'b1;
            if (lat == kcyc + 1) begin
                kill = 1'b0;
                check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
            end
        end
        check_val({tag, "_done"}, 32'(n_done), 32'd0);
        check_val({tag, "_res"}, result, prev);
    endtask

    initial begin
        int lat;
        bit seen;
        rst = 1'b1; start = 1'b0; kill = 1'b0;
        funct3 = 3'b000; rs1 = 32'h0; rs2 = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_res", result, 32'h0);
        rst = 1'b0;

        run_op("mul",    3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
        run_op("mulhu",  3'b011, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006, 2);
        run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
        run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run_op("divu",   3'b101, 32'd100, 32'd7, 32'd14, 34);
        run_op("remu",   3'b111, 32'd100, 32'd7, 32'd2, 34);
        run_op("div0",   3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
        run_op("rem0",   3'b110, 32'd5, 32'd0, 32'd5, 2);
        run_op("divu0",  3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
        run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2);

        // A start while busy at cycle 10 must be ignored.
        @(negedge clk);
        issue(3'b101, 32'd1000, 32'd10);
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 60) begin
            @(negedge clk);
            lat++;
            if (done) seen = 1'b1;
            if (lat == 10) begin
                start = 1'b1; funct3 = 3'b000; rs1 = 32'd3; rs2 = 32'd3;
            end
            if (lat == 11) start = 1'b0;
        end
        check_val("ign_lat", 32'(lat), 32'd34);
        check_val("ign_res", result, 32'd100);
        @(negedge clk);
        check_val("ign_idle", {30'd0, busy, done}, 32'd0);

        run_kill("kill20", 20, 32'd100);
        run_kill("killfix", 33, 32'd100);

        // Back-to-back: MUL accepted in the DONE cycle of a divide.
        @(negedge clk);
        issue(3'b100, 32'd50, 32'd5);
        wait_done("b2b_div", 32'd10, 34);
        issue(3'b000, 32'd6, 32'd7);
        wait_done("b2b_mul", 32'd42, 2);

        // Reset in the middle of a divide.
        @(negedge clk);
        issue(3'b101, 32'd77, 32'd7);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("mrst_busy", {31'd0, busy}, 32'd0);
        check_val("mrst_done", {31'd0, done}, 32'd0);
        check_val("mrst_res", result, 32'h0);
        rst = 1'b0;

        run_op("mul_after", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
